tms_sdm_decim: RTL and testbench
================================

# tms_sdm_decim

Per-channel decimator and frame serializer for TMS sigma-delta modulator bitstreams. It sits downstream of the SDM receiver, in the same `CLK` domain. The block takes the NCH×2 synchronized SDM bits and integrates each channel over a programmable window of sample ticks (boxcar/CIC1). At each window close it latches all sums into a shadow bank and streams the unmasked channels out over a valid/ready interface. It also flags frames dropped because the consumer was too slow.

## Interface
Parameters:
- NCH, 19, number of SDM channels (2 bitstreams each)
- WIDTH, 16, accumulator / output data width
- CNTW, 16, window-length counter width

Ports:
- CLK  in  1  system clock; all logic synchronous to it
- RESET_N  in  1  synchronous, active-low reset
- ENABLE  in  1  run accumulation; low clears accumulators and window counter
- SAMPLE_EN  in  1  one-cycle sample strobe (CLKFF rate); DIN is valid when high
- DIN  in  NCH*2  SDM bits; channel i = {DIN[2i+1], DIN[2i]}
- WINDOW  in  CNTW  samples per frame; latched at ENABLE rise and at each window close
- CH_MASK  in  NCH  1 = channel included in output; latched with each frame
- DOUT_VALID  out  1  beat valid
- DOUT_READY  in  1  consumer accepts beat
- DOUT_DATA  out  WIDTH  channel sum
- DOUT_CH  out  8  channel index of beat
- DOUT_LAST  out  1  last unmasked channel of the frame
- FRAME_CNT  out  16  number of windows closed since enable (wraps)
- OVERFLOW  out  1  sticky: a frame was dropped

## Operation
- Sample value per channel = DIN[2i] + DIN[2i+1], range 0..2. Accumulators add it on each SAMPLE_EN while ENABLE=1 and the latched WINDOW ≠ 0. Accumulators saturate at 2^WIDTH−1 with no wrap.
- Window counter counts SAMPLE_EN pulses. The pulse with count == WINDOW−1 closes the window. On that edge:
  - shadow ← acc + sample (the closing sample is included);
  - acc ← 0; count ← 0;
  - FRAME_CNT++;
  - WINDOW and CH_MASK are re-latched.
- WINDOW = 0: no accumulation and no frames. WINDOW = 1: every sample closes a frame.
- Serializer FSM:
  - **S_IDLE → S_SEND** at a window close while in S_IDLE, provided the latched mask is nonzero.
  - In **S_SEND**, a priority encoder selects the lowest remaining unmasked channel. A beat completes on VALID&&READY, and that channel's bit is cleared from the remaining mask.
  - **S_SEND → S_IDLE** after the beat with DOUT_LAST=1.
  - If the latched mask is all zero, no beats are sent; FRAME_CNT still increments.
- Window close while in S_SEND:
  - shadow and remaining mask are untouched;
  - the new frame is dropped and OVERFLOW is set;
  - FRAME_CNT still increments;
  - accumulators restart normally.
- OVERFLOW is cleared only by reset or by ENABLE=0.
- ENABLE falling: accumulators, window counter and FRAME_CNT clear on the next edge. An in-flight frame completes its transfer.
- SAMPLE_EN and a window close in the same cycle as the final handshake: the FSM goes straight to S_SEND with the new frame. This is not an overflow.

## Timing
- Reset values (RESET_N=0 at an edge):
  - DOUT_VALID, DOUT_LAST, OVERFLOW = 0;
  - DOUT_DATA, DOUT_CH, FRAME_CNT = 0;
  - accumulators, counters and shadow = 0;
  - FSM = S_IDLE.
- Reset mid-transfer abandons the frame immediately.
- Latency: window-closing SAMPLE_EN sampled at edge t → DOUT_VALID=1 with the first beat from cycle t+1.
- Throughput: one beat per cycle while READY=1. A frame of k unmasked channels takes k cycles minimum.
- While VALID=1 and READY=0, DOUT_DATA, DOUT_CH and DOUT_LAST hold stable. VALID never drops without a handshake, except on reset.
- All outputs are registered; no combinational path from DOUT_READY to DOUT_VALID.

## Structure
- Package tms_sdm_pkg:
  - serializer state enum (S_IDLE, S_SEND);
  - SAMPLE_MAX = 2;
  - DOUT_CH width constant (8).
- Sub-module tms_sdm_accum: one saturating WIDTH-bit accumulator with add/clear/snapshot controls, generated NCH times.
- The top level holds the window counter, shadow bank, mask priority encoder and serializer FSM.

## Test plan
- NCH=19, WINDOW=4, DIN all ones, CH_MASK all ones, READY=1 → 19 beats with DATA=8, CH=0..18, LAST on CH=18; VALID rises 1 cycle after the 4th SAMPLE_EN.
- WIDTH=4, WINDOW=10, DIN all ones → DATA saturates at 15 for every channel, no wrap.
- CH_MASK=0b101, WINDOW=2 → beats only for CH=0 and CH=2, LAST on CH=2; CH_MASK=0 → no beats, FRAME_CNT still +1 per window.
- READY=0 across two window closes, WINDOW=1 → OVERFLOW=1, first frame's data held stable and delivered intact once READY=1; FRAME_CNT=2.
- ENABLE toggled low mid-window, then WINDOW=3 → first frame sums include only post-enable samples; OVERFLOW and FRAME_CNT cleared.
- RESET_N=0 asserted mid-transfer → next edge VALID=0, FSM idle, all outputs 0; normal operation resumes after release.

Source files
------------

// File: rtl/tms_sdm_pkg.sv
// Shared types and constants for the TMS sigma-delta decimator.
// The serializer state encoding, sample range and channel-index width live here.
package tms_sdm_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    localparam int SAMPLE_MAX = 2;
    localparam int SAMPLE_W   = $clog2(SAMPLE_MAX + 1);
    localparam int CH_W       = 8;

    // One channel's two bitstreams summed into a 0..SAMPLE_MAX sample value.
    function automatic logic [SAMPLE_W-1:0] sdm_sample(input logic [1:0] bits);
        return SAMPLE_W'(bits[0]) + SAMPLE_W'(bits[1]);
    endfunction

endpackage

// File: rtl/tms_sdm_accum.sv
// One saturating boxcar accumulator with a snapshot register.
// The sum output is the value the accumulator would take on this edge.
module tms_sdm_accum
    import tms_sdm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add,
    input  logic                snap,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [WIDTH-1:0]    sum,
    output logic [WIDTH-1:0]    shadow
);

    logic [WIDTH-1:0] acc_r;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
        logic [WIDTH:0] t;
        t = {1'b0, a} + (WIDTH+1)'(b);
        if (t[WIDTH]) begin
            sat_add = {WIDTH{1'b1}};
        end else begin
            sat_add = t[WIDTH-1:0];
        end
    endfunction

    // Next accumulator value, including the current sample when adding.
    always_comb begin
        sum = acc_r;
        if (add) begin
            sum = sat_add(acc_r, sample);
        end else begin
            sum = acc_r;
        end
    end

    // Accumulator register: clear has priority over add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (add) begin
            acc_r <= sum;
        end
    end

    // Snapshot captures the sum including the window-closing sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= {WIDTH{1'b0}};
        end else if (snap) begin
            shadow <= sum;
        end
    end

endmodule

// File: rtl/tms_sdm_decim.sv
// Per-channel SDM decimator: window counter, shadow bank and valid/ready frame serializer.
// Frames closing while a previous frame is still being sent are dropped and flagged.
module tms_sdm_decim
    import tms_sdm_pkg::*;
#(
    parameter int NCH   = 19,
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic               SAMPLE_EN,
    input  logic [NCH*2-1:0]   DIN,
    input  logic [CNTW-1:0]    WINDOW,
    input  logic [NCH-1:0]     CH_MASK,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic [WIDTH-1:0]   DOUT_DATA,
    output logic [CH_W-1:0]    DOUT_CH,
    output logic               DOUT_LAST,
    output logic [15:0]        FRAME_CNT,
    output logic               OVERFLOW
);

    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             enable_d_r;
    logic [CNTW-1:0]  window_r;
    logic [CNTW-1:0]  count_r;
    logic [NCH-1:0]   mask_r;
    logic [NCH-1:0]   rem_r;
    ser_state_e       state_r;

    logic             rise_s;
    logic [CNTW-1:0]  win_cur_s;
    logic [NCH-1:0]   mask_cur_s;
    logic             add_s;
    logic             close_s;
    logic             clr_s;
    logic             snap_s;
    logic             ovf_set_s;
    logic             hs_s;
    logic             free_s;
    logic [IDXW-1:0]  cur_idx_s;
    logic [IDXW-1:0]  pick_idx_s;
    logic [IDXW-1:0]  load_idx_s;
    logic [NCH-1:0]   rem_after_s;

    ser_state_e       state_n;
    logic [NCH-1:0]   rem_n;
    logic             valid_n;
    logic             last_n;
    logic [WIDTH-1:0] data_n;
    logic [CH_W-1:0]  ch_n;

    logic [WIDTH-1:0] sum_s    [NCH];
    logic [WIDTH-1:0] shadow_s [NCH];

    function automatic logic [IDXW-1:0] low_idx(input logic [NCH-1:0] m);
        low_idx = {IDXW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                low_idx = IDXW'(i);
            end
        end
    endfunction

    function automatic logic [NCH-1:0] idx_bit(input logic [IDXW-1:0] i);
        idx_bit = {{(NCH-1){1'b0}}, 1'b1} << i;
    endfunction

    // On the enable edge the live WINDOW/CH_MASK apply before the latch has caught them.
    assign rise_s      = ENABLE & ~enable_d_r;
    assign win_cur_s   = rise_s ? WINDOW  : window_r;
    assign mask_cur_s  = rise_s ? CH_MASK : mask_r;
    assign add_s       = ENABLE && SAMPLE_EN && (win_cur_s != {CNTW{1'b0}});
    assign close_s     = add_s && (count_r == win_cur_s - CNTW'(1));
    assign clr_s       = !ENABLE || close_s;
    assign hs_s        = DOUT_VALID && DOUT_READY;
    assign cur_idx_s   = DOUT_CH[IDXW-1:0];
    assign rem_after_s = rem_r & ~idx_bit(cur_idx_s);
    assign pick_idx_s  = low_idx(rem_after_s);
    assign load_idx_s  = low_idx(mask_cur_s);

    for (genvar i = 0; i < NCH; i++) begin : g_acc
        tms_sdm_accum #(.WIDTH(WIDTH)) u_acc (
            .clk    (CLK),
            .rst_n  (RESET_N),
            .clr    (clr_s),
            .add    (add_s),
            .snap   (snap_s),
            .sample (sdm_sample(DIN[2*i+1 -: 2])),
            .sum    (sum_s[i]),
            .shadow (shadow_s[i])
        );
    end

    // Window counter, parameter latches, frame counter and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            enable_d_r <= 1'b0;
            window_r   <= {CNTW{1'b0}};
            mask_r     <= {NCH{1'b0}};
            count_r    <= {CNTW{1'b0}};
            FRAME_CNT  <= 16'd0;
            OVERFLOW   <= 1'b0;
        end else begin
            enable_d_r <= ENABLE;
            if (rise_s || close_s) begin
                window_r <= WINDOW;
                mask_r   <= CH_MASK;
            end
            if (!ENABLE || close_s) begin
                count_r <= {CNTW{1'b0}};
            end else if (add_s) begin
                count_r <= count_r + CNTW'(1);
            end
            if (!ENABLE) begin
                FRAME_CNT <= 16'd0;
                OVERFLOW  <= 1'b0;
            end else begin
                if (close_s) begin
                    FRAME_CNT <= FRAME_CNT + 16'd1;
                end
                if (ovf_set_s) begin
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

    // Serializer next state; a new frame's first beat comes straight from the live sums.
    always_comb begin
        state_n   = state_r;
        rem_n     = rem_r;
        valid_n   = DOUT_VALID;
        data_n    = DOUT_DATA;
        ch_n      = DOUT_CH;
        last_n    = DOUT_LAST;
        snap_s    = 1'b0;
        ovf_set_s = 1'b0;
        free_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                free_s = 1'b1;
            end
            S_SEND: begin
                if (hs_s && DOUT_LAST) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    rem_n   = {NCH{1'b0}};
                    free_s  = 1'b1;
                end else if (hs_s) begin
                    rem_n  = rem_after_s;
                    data_n = shadow_s[pick_idx_s];
                    ch_n   = CH_W'(pick_idx_s);
                    last_n = ((rem_after_s & ~idx_bit(pick_idx_s)) == {NCH{1'b0}});
                end else begin
                    free_s = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                free_s  = 1'b1;
            end
        endcase
        if (close_s && free_s) begin
            snap_s = 1'b1;
            if (mask_cur_s != {NCH{1'b0}}) begin
                state_n = S_SEND;
                rem_n   = mask_cur_s;
                valid_n = 1'b1;
                data_n  = sum_s[load_idx_s];
                ch_n    = CH_W'(load_idx_s);
                last_n  = ((mask_cur_s & ~idx_bit(load_idx_s)) == {NCH{1'b0}});
            end else begin
                snap_s = 1'b1;
            end
        end else if (close_s) begin
            ovf_set_s = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end
    end

    // Serializer state and registered output beat.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r    <= S_IDLE;
            rem_r      <= {NCH{1'b0}};
            DOUT_VALID <= 1'b0;
            DOUT_DATA  <= {WIDTH{1'b0}};
            DOUT_CH    <= {CH_W{1'b0}};
            DOUT_LAST  <= 1'b0;
        end else begin
            state_r    <= state_n;
            rem_r      <= rem_n;
            DOUT_VALID <= valid_n;
            DOUT_DATA  <= data_n;
            DOUT_CH    <= ch_n;
            DOUT_LAST  <= last_n;
        end
    end

endmodule

// File: tb/tb_tms_sdm_decim.sv
// Directed bench for tms_sdm_decim: a 16-bit instance and a 4-bit instance share all inputs,
// the narrow one exercising saturation.
module tb_tms_sdm_decim;

    localparam int NCH  = 19;
    localparam int CNTW = 16;
    localparam logic [NCH-1:0]   ALL_CH   = {NCH{1'b1}};
    localparam logic [2*NCH-1:0] DIN_ONES = {(2*NCH){1'b1}};
    localparam logic [2*NCH-1:0] DIN_HALF = {NCH{2'b01}};

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             sample_en;
    logic [2*NCH-1:0] din;
    logic [CNTW-1:0]  window;
    logic [NCH-1:0]   ch_mask;
    logic             dout_ready;

    logic        m_valid, m_last, m_ovf;
    logic [15:0] m_data, m_frame;
    logic [7:0]  m_ch;
    logic        s_valid, s_last, s_ovf;
    logic [3:0]  s_data;
    logic [15:0] s_frame;
    logic [7:0]  s_ch;

    int n_cmp = 0;
    int n_err = 0;

    tms_sdm_decim #(.NCH(NCH), .WIDTH(16), .CNTW(CNTW)) dut (
        .CLK(clk), .RESET_N(reset_n), .ENABLE(enable), .SAMPLE_EN(sample_en),
        .DIN(din), .WINDOW(window), .CH_MASK(ch_mask),
        .DOUT_VALID(m_valid), .DOUT_READY(dout_ready), .DOUT_DATA(m_data),
        .DOUT_CH(m_ch), .DOUT_LAST(m_last), .FRAME_CNT(m_frame), .OVERFLOW(m_ovf)
    );

    tms_sdm_decim #(.NCH(NCH), .WIDTH(4), .CNTW(CNTW)) dut_sat (
        .CLK(clk), .RESET_N(reset_n), .ENABLE(enable), .SAMPLE_EN(sample_en),
        .DIN(din), .WINDOW(window), .CH_MASK(ch_mask),
        .DOUT_VALID(s_valid), .DOUT_READY(dout_ready), .DOUT_DATA(s_data),
        .DOUT_CH(s_ch), .DOUT_LAST(s_last), .FRAME_CNT(s_frame), .OVERFLOW(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input int n);
        sample_en = 1'b1;
        repeat (n) tick();
        sample_en = 1'b0;
    endtask

    // Expects one beat per unmasked channel, ascending, with READY already high.
    task automatic recv(input logic [NCH-1:0] mask, input int exp_main, input int exp_small);
        int w;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
                w = 0;
                while (!m_valid && w < 50) begin
                    tick();
                    w++;
                end
                chk("beat_valid", 32'(m_valid), 32'd1);
                chk("beat_ch", 32'(m_ch), 32'(i));
                chk("beat_data", 32'(m_data), 32'(exp_main));
                chk("beat_last", 32'(m_last), 32'((mask >> (i + 1)) == {NCH{1'b0}}));
                chk("sat_data", 32'(s_data), 32'(exp_small));
                chk("sat_ch", 32'(s_ch), 32'(i));
                tick();
            end
        end
        chk("frame_end_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; sample_en = 1'b0; din = DIN_ONES;
        window = 16'd4; ch_mask = ALL_CH; dout_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_ch", 32'(m_ch), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_frame", 32'(m_frame), 32'd0);
        chk("rst_ovf", 32'(m_ovf), 32'd0);

        // Window 4, all ones: every channel sums to 8.
        reset_n = 1'b1; enable = 1'b1;
        tick();
        samples(3);
        chk("lat_before", 32'(m_valid), 32'd0);
        samples(1);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_frame", 32'(m_frame), 32'd1);
        recv(ALL_CH, 8, 8);

        // Window 10: 20 in the wide instance, clamped at 15 in the 4-bit one.
        enable = 1'b0; tick();
        window = 16'd10; enable = 1'b1; tick();
        samples(10);
        recv(ALL_CH, 20, 15);
        chk("sat_frame", 32'(s_frame), 32'd1);
        chk("sat_ovf", 32'(s_ovf), 32'd0);

        // Sparse mask, then an empty mask that still counts frames.
        enable = 1'b0; tick();
        ch_mask = 19'b101; window = 16'd2; enable = 1'b1; tick();
        samples(2);
        recv(19'b101, 4, 4);
        chk("mask_frame", 32'(m_frame), 32'd1);
        enable = 1'b0; tick();
        ch_mask = 19'd0; enable = 1'b1; tick();
        samples(2);
        chk("zmask_valid", 32'(m_valid), 32'd0);
        chk("zmask_frame1", 32'(m_frame), 32'd1);
        samples(2);
        chk("zmask_frame2", 32'(m_frame), 32'd2);
        chk("zmask_valid2", 32'(m_valid), 32'd0);

        // Back-pressure across two closes with window 1.
        enable = 1'b0; tick();
        window = 16'd1; ch_mask = 19'h3; dout_ready = 1'b0; din = DIN_ONES;
        enable = 1'b1; tick();
        samples(1);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'd2);
        chk("bp_ovf0", 32'(m_ovf), 32'd0);
        din = {(2*NCH){1'b0}};
        samples(1);
        chk("bp_ovf1", 32'(m_ovf), 32'd1);
        chk("bp_frame", 32'(m_frame), 32'd2);
        repeat (3) tick();
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        chk("bp_hold_data", 32'(m_data), 32'd2);
        chk("bp_hold_ch", 32'(m_ch), 32'd0);
        chk("bp_hold_last", 32'(m_last), 32'd0);
        dout_ready = 1'b1;
        recv(19'h3, 2, 2);
        chk("bp_ovf_sticky", 32'(m_ovf), 32'd1);

        // Disable clears overflow and frame count; mid-window samples are discarded.
        enable = 1'b0; tick();
        chk("dis_ovf", 32'(m_ovf), 32'd0);
        chk("dis_frame", 32'(m_frame), 32'd0);
        window = 16'd3; din = DIN_ONES; enable = 1'b1; tick();
        samples(2);
        enable = 1'b0; tick();
        chk("mid_valid", 32'(m_valid), 32'd0);
        din = DIN_HALF; enable = 1'b1; tick();
        samples(3);
        recv(19'h3, 3, 3);
        chk("reen_frame", 32'(m_frame), 32'd1);

        // Reset in the middle of a transfer.
        enable = 1'b0; tick();
        ch_mask = ALL_CH; din = DIN_ONES; enable = 1'b1; tick();
        samples(3);
        repeat (2) tick();
        chk("pre_rst_ch", 32'(m_ch), 32'd2);
        reset_n = 1'b0; tick();
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_data", 32'(m_data), 32'd0);
        chk("mrst_ch", 32'(m_ch), 32'd0);
        chk("mrst_last", 32'(m_last), 32'd0);
        chk("mrst_frame", 32'(m_frame), 32'd0);
        reset_n = 1'b1; tick();
        samples(3);
        recv(ALL_CH, 6, 6);
        chk("post_rst_frame", 32'(m_frame), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
